pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter DELAY_SLOT, default 1: 1 = branch delay slot, no IF squash; 0 = squash IF/ID on taken branch/jump.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  input  1 each  the ID instruction actually reads rs/rt.
REQ-007 id_wreg, id_m2reg  input  1 each  ID instruction writes regfile / its result comes from memory.
REQ-008 id_wn  input  5  destination register number of the ID instruction.
REQ-009 id_jump_taken  input  1  ID resolved a taken branch or jump this cycle.
REQ-010 wpcir  output  1  write enable for the PC and IF/ID registers; 0 holds both.
REQ-011 bubble  output  1  forces wreg/m2reg/wmem/jal into ID/EX to 0.
REQ-012 flush_if  output  1  replaces the IF/ID instruction with a NOP.
REQ-013 fwd_a, fwd_b  output  2 each  operand source: 0 regfile, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data.
REQ-014 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-015 The block SHALL keep shadow stage state: ex_{wreg,m2reg,wn} and mem_{wreg,m2reg,wn}, updated each posedge.
REQ-016 Each cycle ex_* SHALL load id_wreg/id_m2reg/id_wn, or all zeros when bubble=1; mem_* SHALL load ex_*.
REQ-017 Load-use hazard SHALL be: ex_wreg & ex_m2reg & ex_wn!=0 & ((id_use_rs & ex_wn==id_rs) | (id_use_rt & ex_wn==id_rt)).
REQ-018 On a load-use hazard, same cycle (combinational): wpcir=0, bubble=1. Otherwise wpcir=1, bubble=0.
REQ-019 A load-use stall SHALL last exactly one cycle. The bubble clears ex_m2reg, so the next cycle resolves through fwd=3.
REQ-020 fwd_a SHALL be 1 when ex_wreg & !ex_m2reg & ex_wn!=0 & ex_wn==id_rs.
REQ-021 Else fwd_a SHALL be 2 when mem_wreg & !mem_m2reg & mem_wn!=0 & mem_wn==id_rs.
REQ-022 Else fwd_a SHALL be 3 when mem_wreg & mem_m2reg & mem_wn!=0 & mem_wn==id_rs; else 0.
REQ-023 fwd_b SHALL follow REQ-020..022 identically using id_rt; the EX match always has priority over the MEM match.
REQ-024 With id_use_rs=0, fwd_a SHALL be 0; with id_use_rt=0, fwd_b SHALL be 0.
REQ-025 flush_if SHALL be id_jump_taken & !stall & (DELAY_SLOT==0); it is always 0 when DELAY_SLOT=1.
REQ-026 Stall and taken jump in the same cycle: the stall wins, flush_if=0, and the jump is re-evaluated next cycle.
REQ-027 stall_cnt SHALL increment on each stall cycle and saturate at all-ones.
REQ-028 flush_cnt SHALL increment on each flush_if cycle and saturate at all-ones.
REQ-029 Register 0 SHALL never cause a stall or a non-zero forward.

Reset
REQ-030 While reset=1 at posedge, all shadow state and both counters SHALL clear to 0 (nop in every stage).
REQ-031 After reset, outputs SHALL be wpcir=1, bubble=0, flush_if=0, fwd_a=fwd_b=0.
REQ-032 Reset asserted during a stall SHALL drop the stall after the next posedge; no stall resumes.

Structure
REQ-033 Forwarding encodings (FWD_RF=0, FWD_EXALU=1, FWD_MEMALU=2, FWD_MEMLD=3) SHALL live in the shared pipeline constants package.
REQ-034 A single sub-module, fwd_sel, SHALL compute one 2-bit select; it is instantiated once for rs and once for rt.

Verification
REQ-035 Scenario: lw r3 then add r4,r3,r5 -> one cycle wpcir=0, bubble=1, stall_cnt=1; next cycle fwd_a=3, wpcir=1.
REQ-036 Scenario: add r2 then sub r6,r2,r2 -> fwd_a=fwd_b=1 with no stall; the following instruction reading r2 gets fwd=2.
REQ-037 Scenario: add r7 then add r7 then or r8,r7,r0 -> fwd_a=1 (EX priority); fwd_b=0.
REQ-038 Scenario: lw r0 then add r1,r0,r0 -> no stall; fwd_a=fwd_b=0.
REQ-039 Scenario: DELAY_SLOT=0, id_jump_taken=1 with no hazard -> flush_if=1, flush_cnt=1; with a simultaneous load-use -> flush_if=0, bubble=1.
REQ-040 Scenario: CNT_W=4, 20 consecutive load-use pairs -> stall_cnt holds at 15; reset=1 -> counters 0 and wpcir=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
//   Shared pipeline constants for the hazard/forwarding controller.
//   - fwd_e      : operand source select encodings used by both forwarding muxes
//   - reg_num_t  : register-file index type (32 architectural registers)
//   - stage_t    : the slice of an instruction the controller tracks per stage
//   - STAGE_NOP  : stage contents of a bubble / reset slot
//   - writes_reg : does a stage produce a value for register r (r0 excluded)
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_RF     = 2'd0,  // register file read
      FWD_EXALU  = 2'd1,  // ALU result of the instruction in EX
      FWD_MEMALU = 2'd2,  // ALU result of the instruction in MEM
      FWD_MEMLD  = 2'd3   // load data of the instruction in MEM
   } fwd_e;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] reg_num_t;

   typedef struct packed {
      logic     wreg;   // writes the register file
      logic     m2reg;  // result comes from data memory
      reg_num_t wn;     // destination register
   } stage_t;

   localparam stage_t STAGE_NOP = '{wreg: 1'b0, m2reg: 1'b0, wn: '0};

   // r0 is hardwired to zero, so a write to it never produces a usable value.
   function automatic logic writes_reg(input stage_t s, input reg_num_t r);
      return s.wreg && (s.wn != '0) && (s.wn == r);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
//   Chooses the source for one ID-stage operand.
//   Ports:
//     use_r  (in)  the ID instruction really reads this operand
//     r      (in)  source register number of the operand
//     ex     (in)  shadow state of the instruction in EX
//     mem    (in)  shadow state of the instruction in MEM
//     sel    (out) 2-bit source select (fwd_e encoding)
//   The EX producer is the youngest, so an EX ALU match wins over any MEM
//   match. A load sitting in EX cannot be forwarded (its data does not exist
//   yet); that case is handled by the load-use stall in the top level.
// ---------------------------------------------------------------------------
module fwd_sel
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic     use_r,
   input  reg_num_t r,
   input  stage_t   ex,
   input  stage_t   mem,
   output logic [1:0] sel
);

   fwd_e sel_e;

   always_comb begin
      sel_e = FWD_RF;
      if (use_r) begin
         if (writes_reg(ex, r) && !ex.m2reg) begin
            sel_e = FWD_EXALU;
         end else if (writes_reg(mem, r)) begin
            sel_e = mem.m2reg ? FWD_MEMLD : FWD_MEMALU;
         end
      end
   end

   assign sel = sel_e;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard detection and operand forwarding for a 5-stage in-order pipeline.
//   Tracks the destination info of the instructions in EX and MEM, detects
//   load-use hazards (one-cycle stall plus bubble), selects forwarding paths
//   for both ID operands and optionally squashes IF on a taken branch/jump.
//
//   Parameters:
//     DELAY_SLOT  1 = architectural branch delay slot (never squash IF)
//                 0 = squash the IF/ID instruction on a taken branch/jump
//     CNT_W       width of the saturating performance counters
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     id_rs, id_rt        source registers of the ID instruction
//     id_use_rs/rt        ID instruction really reads rs/rt
//     id_wreg, id_m2reg   ID instruction writes regfile / is a load
//     id_wn               destination register of the ID instruction
//     id_jump_taken       ID resolved a taken branch or jump
//     wpcir               PC and IF/ID write enable (0 = hold)
//     bubble              zero the control bits going into ID/EX
//     flush_if            replace the IF/ID instruction by a NOP
//     fwd_a, fwd_b        operand source selects (fwd_e encoding)
//     stall_cnt           number of stall cycles, saturating
//     flush_cnt           number of IF squash cycles, saturating
//
//   Handshake: there is no valid/ready pair here; wpcir is the only
//   back-pressure. When wpcir=0 the ID instruction is held and presented
//   again next cycle, while a bubble (all-zero control) enters EX.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int DELAY_SLOT = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wreg,
   input  logic             id_m2reg,
   input  logic [4:0]       id_wn,
   input  logic             id_jump_taken,
   output logic             wpcir,
   output logic             bubble,
   output logic             flush_if,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic             SQUASH_IF = (DELAY_SLOT == 0);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   stage_t id_stage;
   stage_t ex_d;
   stage_t ex_q;
   stage_t mem_q;
   logic   rs_hit;
   logic   rt_hit;
   logic   load_use;

   assign id_stage = '{wreg: id_wreg, m2reg: id_m2reg, wn: id_wn};

   // A load in EX delivers its data only at the end of MEM, so any consumer
   // directly behind it must wait one cycle. After that cycle the load is in
   // MEM and the FWD_MEMLD path covers it.
   always_comb begin
      rs_hit   = id_use_rs && (ex_q.wn == id_rs);
      rt_hit   = id_use_rt && (ex_q.wn == id_rt);
      load_use = ex_q.wreg && ex_q.m2reg && (ex_q.wn != '0) && (rs_hit || rt_hit);
   end

   // Stall beats a taken jump: the jump is held in ID and re-resolved next
   // cycle, so squashing IF now would lose the held slot.
   always_comb begin
      wpcir    = !load_use;
      bubble   = load_use;
      flush_if = SQUASH_IF && id_jump_taken && !load_use;
      ex_d     = load_use ? STAGE_NOP : id_stage;
   end

   fwd_sel u_fwd_rs (
      .use_r (id_use_rs),
      .r     (id_rs),
      .ex    (ex_q),
      .mem   (mem_q),
      .sel   (fwd_a)
   );

   fwd_sel u_fwd_rt (
      .use_r (id_use_rt),
      .r     (id_rt),
      .ex    (ex_q),
      .mem   (mem_q),
      .sel   (fwd_b)
   );

   // Shadow copies of the EX and MEM stage control fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= STAGE_NOP;
         mem_q <= STAGE_NOP;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (load_use && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (flush_if && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Two instances share the same stimulus: dut1 (DELAY_SLOT=1, CNT_W=16) and
//   dut0 (DELAY_SLOT=0, CNT_W=4). Inputs change on the falling edge and
//   outputs are sampled 1 ns later; state moves on the rising edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, id_wn;
   logic        id_use_rs, id_use_rt, id_wreg, id_m2reg, id_jump_taken;

   logic        wpcir1, bubble1, flush1;
   logic [1:0]  fa1, fb1;
   logic [15:0] scnt1, fcnt1;
   logic        wpcir0, bubble0, flush0;
   logic [1:0]  fa0, fb0;
   logic [3:0]  scnt0, fcnt0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.DELAY_SLOT(1), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
      .id_m2reg(id_m2reg), .id_wn(id_wn), .id_jump_taken(id_jump_taken),
      .wpcir(wpcir1), .bubble(bubble1), .flush_if(flush1),
      .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
   );

   pipeline_hazard_ctrl #(.DELAY_SLOT(0), .CNT_W(4)) dut0 (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
      .id_m2reg(id_m2reg), .id_wn(id_wn), .id_jump_taken(id_jump_taken),
      .wpcir(wpcir0), .bubble(bubble0), .flush_if(flush0),
      .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(scnt0), .flush_cnt(fcnt0)
   );

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                         input bit wreg, input bit m2r, input int wn, input bit jmp);
      id_rs         = 5'(rs);
      id_rt         = 5'(rt);
      id_use_rs     = urs;
      id_use_rt     = urt;
      id_wreg       = wreg;
      id_m2reg      = m2r;
      id_wn         = 5'(wn);
      id_jump_taken = jmp;
   endtask

   task automatic nop_in();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int rs, rt; bit urs, urt, wreg, m2r; int wn; bit jmp;
      bit e_wpcir, e_bub, e_fl0; int e_fa, e_fb, e_scnt, e_fcnt0;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(int rs, int rt, bit urs, bit urt, bit wreg, bit m2r,
                               int wn, bit jmp, bit wp, bit bub, bit fl0,
                               int fa, int fb, int sc, int fc);
      vec_t v;
      v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.wreg = wreg; v.m2r = m2r;
      v.wn = wn; v.jmp = jmp; v.e_wpcir = wp; v.e_bub = bub; v.e_fl0 = fl0;
      v.e_fa = fa; v.e_fb = fb; v.e_scnt = sc; v.e_fcnt0 = fc;
      return v;
   endfunction

   // ---------------- reference model ----------------
   // The two in-flight instructions ahead of ID, youngest first.
   typedef struct { bit wreg; bit m2reg; int wn; } ins_t;
   ins_t pipe[2];
   int   m_stalls, m_flushes;

   function automatic bit produces(int stage, int r);
      return pipe[stage].wreg && r != 0 && pipe[stage].wn == r;
   endfunction

   function automatic int model_fwd(bit use_r, int r);
      if (!use_r) return 0;
      if (produces(0, r) && !pipe[0].m2reg) return 1;
      if (produces(1, r)) return pipe[1].m2reg ? 3 : 2;
      return 0;
   endfunction

   function automatic bit model_stall();
      return pipe[0].m2reg &&
             ((id_use_rs && produces(0, int'(id_rs))) || (id_use_rt && produces(0, int'(id_rt))));
   endfunction

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(1,0,1,0,1,1,3,0, 1,0,0, 0,0, 0,0);  // lw r3,0(r1)
      tbl[1]  = mk(3,5,1,1,1,0,4,0, 0,1,0, 0,0, 0,0);  // add r4,r3,r5: load-use stall
      tbl[2]  = mk(3,5,1,1,1,0,4,0, 1,0,0, 3,0, 1,0);  // held add: load data from MEM
      tbl[3]  = mk(1,1,1,1,1,0,2,0, 1,0,0, 0,0, 1,0);  // add r2,r1,r1
      tbl[4]  = mk(2,2,1,1,1,0,6,0, 1,0,0, 1,1, 1,0);  // sub r6,r2,r2: EX ALU both
      tbl[5]  = mk(2,0,1,1,1,0,9,0, 1,0,0, 2,0, 1,0);  // and r9,r2,r0: MEM ALU
      tbl[6]  = mk(1,1,1,1,1,0,7,0, 1,0,0, 0,0, 1,0);  // add r7
      tbl[7]  = mk(1,1,1,1,1,0,7,0, 1,0,0, 0,0, 1,0);  // add r7 again
      tbl[8]  = mk(7,0,1,1,1,0,8,0, 1,0,0, 1,0, 1,0);  // or r8,r7,r0: EX priority
      tbl[9]  = mk(1,0,1,0,1,1,0,0, 1,0,0, 0,0, 1,0);  // lw r0
      tbl[10] = mk(0,0,1,1,1,0,1,0, 1,0,0, 0,0, 1,0);  // add r1,r0,r0: no stall
      tbl[11] = mk(1,1,1,1,0,0,0,1, 1,0,1, 1,1, 1,0);  // beq r1,r1 taken
      tbl[12] = mk(2,0,1,0,1,1,5,0, 1,0,0, 0,0, 1,1);  // lw r5,0(r2)
      tbl[13] = mk(5,0,1,1,0,0,0,1, 0,1,0, 0,0, 1,1);  // beq r5 taken + load-use
      tbl[14] = mk(5,0,1,1,0,0,0,1, 1,0,1, 3,0, 2,1);  // jump re-evaluated
      tbl[15] = mk(0,0,0,0,0,0,0,0, 1,0,0, 0,0, 2,2);  // nop

      // ---- reset ----
      reset = 1'b1;
      nop_in();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_wpcir", 32'(wpcir1), 1);
      chk("rst_bubble", 32'(bubble1), 0);
      chk("rst_flush0", 32'(flush0), 0);
      chk("rst_fwd_a", 32'(fa1), 0);
      chk("rst_fwd_b", 32'(fb1), 0);
      chk("rst_scnt", 32'(scnt1), 0);
      chk("rst_fcnt0", 32'(fcnt0), 0);

      // ---- directed table ----
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         set_in(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].wreg,
                tbl[i].m2r, tbl[i].wn, tbl[i].jmp);
         #1;
         chk($sformatf("tbl%0d_wpcir", i), 32'(wpcir1), 32'(tbl[i].e_wpcir));
         chk($sformatf("tbl%0d_bubble", i), 32'(bubble1), 32'(tbl[i].e_bub));
         chk($sformatf("tbl%0d_fwd_a", i), 32'(fa1), 32'(tbl[i].e_fa));
         chk($sformatf("tbl%0d_fwd_b", i), 32'(fb1), 32'(tbl[i].e_fb));
         chk($sformatf("tbl%0d_flush1", i), 32'(flush1), 0);
         chk($sformatf("tbl%0d_flush0", i), 32'(flush0), 32'(tbl[i].e_fl0));
         chk($sformatf("tbl%0d_bubble0", i), 32'(bubble0), 32'(tbl[i].e_bub));
         chk($sformatf("tbl%0d_scnt1", i), 32'(scnt1), 32'(tbl[i].e_scnt));
         chk($sformatf("tbl%0d_scnt0", i), 32'(scnt0), 32'(tbl[i].e_scnt));
         chk($sformatf("tbl%0d_fcnt0", i), 32'(fcnt0), 32'(tbl[i].e_fcnt0));
         chk($sformatf("tbl%0d_fcnt1", i), 32'(fcnt1), 0);
      end

      // ---- reset asserted during a stall ----
      @(negedge clk);
      set_in(1, 0, 1, 0, 1, 1, 3, 0);           // lw r3
      @(negedge clk);
      set_in(3, 5, 1, 1, 1, 0, 4, 0);           // add r4,r3,r5
      reset = 1'b1;
      #1;
      chk("rstall_bubble_before", 32'(bubble1), 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rstall_wpcir_after", 32'(wpcir1), 1);
      chk("rstall_bubble_after", 32'(bubble1), 0);
      chk("rstall_fwd_a_after", 32'(fa1), 0);
      chk("rstall_scnt_after", 32'(scnt1), 0);
      @(negedge clk);
      #1;
      chk("rstall_no_resume", 32'(bubble1), 0);

      // ---- counter saturation: 20 load-use pairs ----
      for (int p = 0; p < 20; p++) begin
         @(negedge clk);
         set_in(1, 0, 1, 0, 1, 1, 3, 0);        // lw r3
         @(negedge clk);
         set_in(3, 5, 1, 1, 1, 0, 4, 0);        // stalled add
         @(negedge clk);                        // add proceeds
      end
      #1;
      chk("sat_scnt0", 32'(scnt0), 15);
      chk("sat_scnt1", 32'(scnt1), 20);
      @(negedge clk);
      nop_in();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("sat_rst_scnt0", 32'(scnt0), 0);
      chk("sat_rst_scnt1", 32'(scnt1), 0);
      chk("sat_rst_wpcir", 32'(wpcir1), 1);

      // ---- randomized stimulus against the reference model ----
      for (int c = 0; c < 2000; c++) begin
         bit st;
         int ef;
         @(negedge clk);
         set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0));
         reset = (c == 0) || ($urandom_range(0, 49) == 0);
         #1;
         if (c > 0) begin
            st = model_stall();
            ef = (id_jump_taken && !st) ? 1 : 0;
            chk("rnd_wpcir1", 32'(wpcir1), 32'(!st));
            chk("rnd_bubble1", 32'(bubble1), 32'(st));
            chk("rnd_flush1", 32'(flush1), 0);
            chk("rnd_fwd_a1", 32'(fa1), 32'(model_fwd(id_use_rs, int'(id_rs))));
            chk("rnd_fwd_b1", 32'(fb1), 32'(model_fwd(id_use_rt, int'(id_rt))));
            chk("rnd_scnt1", 32'(scnt1), 32'(sat(m_stalls, 65535)));
            chk("rnd_fcnt1", 32'(fcnt1), 0);
            chk("rnd_wpcir0", 32'(wpcir0), 32'(!st));
            chk("rnd_flush0", 32'(flush0), 32'(ef));
            chk("rnd_fwd_a0", 32'(fa0), 32'(model_fwd(id_use_rs, int'(id_rs))));
            chk("rnd_fwd_b0", 32'(fb0), 32'(model_fwd(id_use_rt, int'(id_rt))));
            chk("rnd_scnt0", 32'(scnt0), 32'(sat(m_stalls, 15)));
            chk("rnd_fcnt0", 32'(fcnt0), 32'(sat(m_flushes, 15)));
            // advance the model across the coming rising edge
            if (!reset) begin
               m_stalls  += st ? 1 : 0;
               m_flushes += ef;
               pipe[1] = pipe[0];
               if (st) pipe[0] = '{0, 0, 0};
               else    pipe[0] = '{id_wreg, id_m2reg, int'(id_wn)};
            end
         end
         if (reset) begin
            pipe[0]   = '{0, 0, 0};
            pipe[1]   = '{0, 0, 0};
            m_stalls  = 0;
            m_flushes = 0;
         end
      end

      @(negedge clk);
      reset = 1'b0;
      nop_in();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
